sram_array_ctrl: RTL
====================

Name: sram_array_ctrl

Overview:
Parametrised synchronous SRAM macro: a DEPTH x DATA_W word array behind a single-port access sequencer.
- The sequencer models single-ended bit-cell timing: bitline precharge, wordline pulse, sense, and write drive.
- Exposes cell-level control strobes (bl_pre, wl_en, sense_en, wr_drv) for waveform correlation with transistor-level cells.
- Serves as the array-level successor to the single bit-cell schematic; the upstream core drives it through a valid/ready request port.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
PRE_CYCLES, 1, bitline precharge duration in clocks (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse, rsp_rdata valid
rsp_rdata  output  DATA_W  read data
wr_done  output  1  one-cycle pulse, write committed
bl_pre  output  1  precharge strobe (high in PRECHARGE)
wl_en  output  1  wordline strobe (high in WORDLINE and WR_WL)
sense_en  output  1  sense strobe (high in SENSE)
wr_drv  output  1  write-driver strobe (high in WR_DRIVE and WR_WL)

Behaviour:
- Reset is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values:
  - FSM = IDLE.
  - req_ready = 1 in the first cycle after rst deasserts; it is 0 while rst is high.
  - rsp_valid = 0, wr_done = 0, rsp_rdata = 0.
  - All strobes = 0; precharge counter = 0.
- Array contents are not initialised and are not touched by reset. Contents are undefined until written and are retained across reset.
- All outputs are registered or decoded from the state register. There is no combinational path from req_* to any output.
- Accept: the request is accepted on an edge where state = IDLE, req_valid = 1 and req_ready = 1.
  - req_we, req_addr and req_wdata are latched on that edge.
  - req_ready = (state == IDLE). Requests while busy are not accepted; the requester must hold them.
- Read path:
  - IDLE -> PRECHARGE for PRE_CYCLES cycles -> WORDLINE (1 cycle) -> SENSE (1 cycle) -> IDLE.
  - rsp_rdata is loaded from the array at the edge leaving SENSE.
  - rsp_valid pulses in the cycle after SENSE. That cycle is IDLE, with req_ready = 1.
  - Read latency from the accept edge to rsp_valid high = PRE_CYCLES + 3 cycles (default 4).
  - rsp_rdata holds its value until the next read completes.
- Write path:
  - IDLE -> WR_DRIVE (1 cycle) -> WR_WL (1 cycle) -> IDLE.
  - The array word is updated on the edge leaving WR_WL.
  - wr_done pulses in the following cycle.
  - Write latency from accept to wr_done = 3 cycles.
- Back-to-back: a new request may be accepted in the same cycle that rsp_valid or wr_done is high. Peak throughput is 1 read per PRE_CYCLES + 3 cycles and 1 write per 3 cycles.
- Address is always in range, since DEPTH = 2**ADDR_W; there is no wrap handling.
- Read-after-write to the same address returns the new data.
- Reset mid-operation aborts to IDLE with no array update.
  - Reset during WR_DRIVE or WR_WL leaves the word unchanged.
  - Reset during a read suppresses rsp_valid and leaves rsp_rdata cleared to 0.
- Strobes are mutually exclusive per state as listed under Ports. In IDLE all strobes are 0.
- Illegal or unused state encodings return to IDLE on the next edge.

Optional Feature:
Macro: SRAM_PARITY_EN
- When defined:
  - Each word stores one extra even-parity bit computed over req_wdata at accept.
  - Added input inj_perr (1 bit): if high at a write accept, the stored parity bit is inverted.
  - Added output rsp_perr (1 bit): registered alongside rsp_rdata. It is 1 when the stored parity does not match the recomputed parity of the read word, is valid with rsp_valid, and resets to 0.
- When not defined: no parity storage, and neither inj_perr nor rsp_perr exists. Timing is identical in both builds.

Test Plan:
1. Reset, then write addr 3 = 0xA5. Expect wr_done 3 cycles after accept; wr_drv high 2 cycles; req_ready low for exactly 2 cycles.
2. Read addr 3 (default PRE_CYCLES = 1). Expect bl_pre, wl_en and sense_en each high 1 cycle in order; rsp_valid at accept + 4 with rsp_rdata = 0xA5. Repeat with PRE_CYCLES = 3: rsp_valid at accept + 6.
3. Write all 16 addresses with data = addr ^ 0x5A, back-to-back with req_valid held high. Read all back, then check every word and that one request is accepted per 3 (write) or 4 (read) cycles.
4. Write addr 7 = 0x11, then write addr 7 = 0x22 with rst pulsed during WR_WL. Read addr 7: expect 0x11 and no wr_done for the aborted write.
5. Assert rst during SENSE of a read. Expect no rsp_valid, rsp_rdata = 0, req_ready = 1 after reset releases; array contents intact.
6. (SRAM_PARITY_EN) Write addr 2 = 0x0F with inj_perr = 1 and addr 4 = 0x0F with inj_perr = 0. Read addr 2: rsp_perr = 1. Read addr 4: rsp_perr = 0.

Source files
------------

// File: rtl/sram_array_ctrl.sv
// -----------------------------------------------------------------------------
// sram_array_ctrl
//
// Purpose:
//   DEPTH x DATA_W synchronous word array (DEPTH = 2**ADDR_W) behind a
//   single-port access sequencer that mimics single-ended bit-cell timing:
//   bitline precharge, wordline pulse, sense, and write drive. The cell-level
//   strobes are exposed so waveforms can be lined up against transistor-level
//   bit-cell simulations.
//
// Optional build macro:
//   SRAM_PARITY_EN - store one even-parity bit per word. This adds the
//                    inj_perr input and the rsp_perr output. Timing is the
//                    same in both builds.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  sequencer idle and able to accept a request
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle pulse, rsp_rdata valid
//   rsp_rdata  out  read data, held until the next read completes
//   wr_done    out  one-cycle pulse, write committed to the array
//   bl_pre     out  precharge strobe
//   wl_en      out  wordline strobe
//   sense_en   out  sense-amp strobe
//   wr_drv     out  write-driver strobe
//   inj_perr   in   (SRAM_PARITY_EN) invert stored parity on this write
//   rsp_perr   out  (SRAM_PARITY_EN) parity mismatch on the returned word
// -----------------------------------------------------------------------------
module sram_array_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int PRE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              bl_pre,
  output logic              wl_en,
  output logic              sense_en,
  output logic              wr_drv
`ifdef SRAM_PARITY_EN
  ,
  input  logic              inj_perr,
  output logic              rsp_perr
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int CNT_W = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    WORDLINE  = 3'd2,
    SENSE     = 3'd3,
    WR_DRIVE  = 3'd4,
    WR_WL     = 3'd5
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  pre_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [MEM_W-1:0]  wword_reg;

  // Storage is deliberately left without reset so it maps onto block RAM
  // and keeps its contents across a reset.
  logic [MEM_W-1:0]  mem [DEPTH];

  // Word to store, latched at accept. With parity enabled the extra MSB
  // makes the XOR of the whole stored word zero (even parity); inj_perr
  // flips it to plant a detectable error.
  logic [MEM_W-1:0]  wword_next;
`ifdef SRAM_PARITY_EN
  assign wword_next = {(^req_wdata) ^ inj_perr, req_wdata};
`else
  assign wword_next = req_wdata;
`endif

  // Handshake and strobes are pure decodes of the state register. req_ready
  // is also masked by rst so it reads 0 for the whole reset pulse.
  assign req_ready = (state_reg == IDLE) && !rst;
  assign bl_pre    = (state_reg == PRECHARGE);
  assign wl_en     = (state_reg == WORDLINE) || (state_reg == WR_WL);
  assign sense_en  = (state_reg == SENSE);
  assign wr_drv    = (state_reg == WR_DRIVE) || (state_reg == WR_WL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pre_cnt_reg <= '0;
      rsp_valid   <= 1'b0;
      wr_done     <= 1'b0;
      rsp_rdata   <= '0;
`ifdef SRAM_PARITY_EN
      rsp_perr    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            wword_reg <= wword_next;
            if (req_we) begin
              state_reg <= WR_DRIVE;
            end else begin
              state_reg   <= PRECHARGE;
              pre_cnt_reg <= CNT_W'(PRE_CYCLES - 1);
            end
          end
        end
        PRECHARGE: begin
          // Counter was loaded with PRE_CYCLES-1 so precharge spans exactly
          // PRE_CYCLES cycles.
          if (pre_cnt_reg == '0) begin
            state_reg <= WORDLINE;
          end else begin
            pre_cnt_reg <= pre_cnt_reg - 1'b1;
          end
        end
        WORDLINE: state_reg <= SENSE;
        SENSE: begin
          rsp_rdata <= mem[addr_reg][DATA_W-1:0];
`ifdef SRAM_PARITY_EN
          // XOR over data plus stored parity is 1 exactly on a mismatch.
          rsp_perr  <= ^mem[addr_reg];
`endif
          rsp_valid <= 1'b1;
          state_reg <= IDLE;
        end
        WR_DRIVE: state_reg <= WR_WL;
        WR_WL: begin
          wr_done   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array commit on the edge leaving WR_WL; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && (state_reg == WR_WL)) begin
      mem[addr_reg] <= wword_reg;
    end
  end

endmodule
